vga_fb_addr_gen: RTL and testbench

Parametrised framebuffer address generator for the VGA path.
- Takes the free-running horizontal/vertical timing counters from the sync generator and produces a registered linear framebuffer read address plus a pixel-valid strobe.
- Supports integer pixel replication (1x/2x/4x), so a 320x240 buffer fills a 640x480 screen, and single or double buffering with a frame-synchronous buffer select.
- Addresses are built incrementally, with no multiplier in the datapath; the output feeds the framebuffer RAM read port.

---
 rtl/vga_pkg.sv | 25 ++
 rtl/vga_fb_addr_gen_if.sv | 31 +++
 rtl/vga_rep_counter.sv | 32 +++
 rtl/vga_fb_addr_gen.sv | 129 ++++++++++++
 tb/tb_vga_fb_addr_gen.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA framebuffer address path.
// Holds the scan-state enum, default 640x480 timing and width helpers.
package vga_pkg;

  typedef enum logic [1:0] {
    SYNC,
    ACTIVE,
    HBLANK,
    VBLANK
  } ag_state_e;

  localparam int DEF_H_START = 112;
  localparam int DEF_H_VIS   = 640;
  localparam int DEF_V_START = 12;
  localparam int DEF_V_VIS   = 480;

  localparam int HOR_W = 11;
  localparam int VER_W = 10;

  // bits needed to hold 0..n-1, never less than 1
  function automatic int cw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vga_fb_addr_gen_if.sv
// Timing-in / address-out bundle of the framebuffer address generator.
// master: the generator (timing in, fbAddr/strobes out); slave: its peer.
interface vga_fb_addr_gen_if
  import vga_pkg::*;
#(
  parameter int ADDR_W = 17
);

  logic              pixEn;
  logic [HOR_W-1:0]  horReg;
  logic [VER_W-1:0]  verReg;
  logic              bufSel;
  logic [ADDR_W-1:0] fbAddr;
  logic              pixValid;
  logic              frameStart;
  logic              lineStart;
  logic              activeBuf;

  modport master (
    input  pixEn, horReg, verReg, bufSel,
    output fbAddr, pixValid, frameStart,
    output lineStart, activeBuf
  );

  modport slave (
    output pixEn, horReg, verReg, bufSel,
    input  fbAddr, pixValid, frameStart,
    input  lineStart, activeBuf
  );

endinterface

// File: rtl/vga_rep_counter.sv
// Modulo-2^S replication counter with clear, enable and wrap strobe.
// Ports: clk, rst_n, clr, en in; wrap out (en while at terminal count).
module vga_rep_counter
  import vga_pkg::*;
#(
  parameter int S = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic wrap
);

  localparam int W = cw(1 << S);
  localparam logic [W-1:0] MAX = W'((1 << S) - 1);

  logic [W-1:0] cnt;

  assign wrap = en && (cnt == MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/vga_fb_addr_gen.sv
// Framebuffer read-address generator with pixel replication and buffers.
// Ports: clock, resetN (async low), bus (master: timing in, address out).
module vga_fb_addr_gen
  import vga_pkg::*;
#(
  parameter int H_START     = DEF_H_START,
  parameter int H_VIS       = DEF_H_VIS,
  parameter int V_START     = DEF_V_START,
  parameter int V_VIS       = DEF_V_VIS,
  parameter int SCALE_SHIFT = 1,
  parameter int NUM_BUFS    = 1,
  parameter int ADDR_W      = 17
) (
  input logic         clock,
  input logic         resetN,
  vga_fb_addr_gen_if.master bus
);

  localparam int FB_W    = H_VIS >> SCALE_SHIFT;
  localparam int FB_H    = V_VIS >> SCALE_SHIFT;
  localparam int FB_SIZE = FB_W * FB_H;

  localparam logic [HOR_W-1:0] HS = HOR_W'(H_START);
  localparam logic [HOR_W-1:0] HL = HOR_W'(H_START + H_VIS - 1);
  localparam logic [VER_W-1:0] VS = VER_W'(V_START);
  localparam logic [VER_W-1:0] VL = VER_W'(V_START + V_VIS - 1);

  localparam logic [ADDR_W-1:0] FB_W_A  = ADDR_W'(FB_W);
  localparam logic [ADDR_W-1:0] FB_SZ_A = ADDR_W'(FB_SIZE);

  if (ADDR_W < $clog2(NUM_BUFS * FB_SIZE) ||
      SCALE_SHIFT < 0 || SCALE_SHIFT > 2 ||
      NUM_BUFS < 1 || NUM_BUFS > 2) begin : g_bad_cfg
    $error("vga_fb_addr_gen: illegal parameter set");
  end

  ag_state_e         state;
  ag_state_e         state_nxt;
  logic [ADDR_W-1:0] line_base;
  logic [ADDR_W-1:0] base;
  logic              buf_nxt;
  logic              ver_vis;
  logic              at_hs;
  logic              at_vl;
  logic              start_frame;
  logic              start_line;
  logic              in_active;
  logic              pix;
  logic              last_col;
  logic              resync;
  logic              col_wrap;
  logic              row_wrap;

  assign buf_nxt = (NUM_BUFS == 2) ? bus.bufSel : 1'b0;
  assign base    = buf_nxt ? FB_SZ_A : '0;

  assign ver_vis = (bus.verReg >= VS) && (bus.verReg <= VL);
  assign at_hs   = bus.horReg == HS;
  assign at_vl   = bus.verReg == VL;

  assign start_frame = (state == SYNC || state == VBLANK) &&
                       at_hs && (bus.verReg == VS);
  assign start_line  = (state == HBLANK) && at_hs && ver_vis;
  assign in_active   = (state == ACTIVE) && ver_vis;
  assign pix         = start_frame | start_line | in_active;
  assign last_col    = pix && (bus.horReg == HL);
  // counters desynced from the scan: drop back and wait for a frame
  assign resync      = (state == ACTIVE || state == HBLANK) && !ver_vis;

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      pix && !last_col:          state_nxt = ACTIVE;
      pix && last_col && at_vl:  state_nxt = VBLANK;
      pix && last_col && !at_vl: state_nxt = HBLANK;
      !pix && resync:            state_nxt = SYNC;
      default:                   state_nxt = state;
    endcase
  end

  vga_rep_counter #(.S(SCALE_SHIFT)) u_col (
    .clk   (clock),
    .rst_n (resetN),
    .clr   (bus.pixEn & (start_frame | start_line)),
    .en    (bus.pixEn & in_active),
    .wrap  (col_wrap)
  );

  vga_rep_counter #(.S(SCALE_SHIFT)) u_row (
    .clk   (clock),
    .rst_n (resetN),
    .clr   (bus.pixEn & start_frame),
    .en    (bus.pixEn & last_col),
    .wrap  (row_wrap)
  );

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state          <= SYNC;
      line_base      <= '0;
      bus.fbAddr     <= '0;
      bus.pixValid   <= 1'b0;
      bus.frameStart <= 1'b0;
      bus.lineStart  <= 1'b0;
      bus.activeBuf  <= 1'b0;
    end else if (bus.pixEn) begin
      state          <= state_nxt;
      bus.pixValid   <= pix;
      bus.frameStart <= start_frame;
      bus.lineStart  <= start_frame | start_line;
      if (start_frame) begin
        bus.activeBuf <= buf_nxt;
        line_base     <= base;
        bus.fbAddr    <= base;
      end else begin
        if (start_line) begin
          bus.fbAddr <= line_base;
        end else if (col_wrap) begin
          bus.fbAddr <= bus.fbAddr + ADDR_W'(1);
        end
        // step to the next buffer row once it has been shown 2^S times
        if (row_wrap) begin
          line_base <= line_base + FB_W_A;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_addr_gen.sv
// Self-checking bench for vga_fb_addr_gen across scale/buffer variants.
// Drives timing counters directly; fast lines jump from first to last pixel.
module tb_vga_fb_addr_gen;
  import vga_pkg::*;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             pix_en;
  logic             bsel;
  logic [HOR_W-1:0] hor;
  logic [VER_W-1:0] ver;

  always #5 clock = ~clock;

  // d0: S=1 single, d1: S=1 double, d2: S=0 single, d3: S=2 single
  vga_fb_addr_gen_if #(.ADDR_W(17)) i0 ();
  vga_fb_addr_gen_if #(.ADDR_W(18)) i1 ();
  vga_fb_addr_gen_if #(.ADDR_W(19)) i2 ();
  vga_fb_addr_gen_if #(.ADDR_W(17)) i3 ();

  assign i0.pixEn = pix_en;
  assign i0.horReg = hor;
  assign i0.verReg = ver;
  assign i0.bufSel = bsel;
  assign i1.pixEn = pix_en;
  assign i1.horReg = hor;
  assign i1.verReg = ver;
  assign i1.bufSel = bsel;
  assign i2.pixEn = pix_en;
  assign i2.horReg = hor;
  assign i2.verReg = ver;
  assign i2.bufSel = bsel;
  assign i3.pixEn = pix_en;
  assign i3.horReg = hor;
  assign i3.verReg = ver;
  assign i3.bufSel = bsel;

  vga_fb_addr_gen #(.SCALE_SHIFT(1), .NUM_BUFS(1), .ADDR_W(17)) u_d0 (
    .clock(clock), .resetN(reset_n), .bus(i0.master));
  vga_fb_addr_gen #(.SCALE_SHIFT(1), .NUM_BUFS(2), .ADDR_W(18)) u_d1 (
    .clock(clock), .resetN(reset_n), .bus(i1.master));
  vga_fb_addr_gen #(.SCALE_SHIFT(0), .NUM_BUFS(1), .ADDR_W(19)) u_d2 (
    .clock(clock), .resetN(reset_n), .bus(i2.master));
  vga_fb_addr_gen #(.SCALE_SHIFT(2), .NUM_BUFS(1), .ADDR_W(17)) u_d3 (
    .clock(clock), .resetN(reset_n), .bus(i3.master));

  logic [31:0] a_o  [4];
  logic        v_o  [4];
  logic        fs_o [4];
  logic        ls_o [4];
  logic        ab_o [4];

  assign a_o[0] = 32'(i0.fbAddr);
  assign a_o[1] = 32'(i1.fbAddr);
  assign a_o[2] = 32'(i2.fbAddr);
  assign a_o[3] = 32'(i3.fbAddr);
  assign v_o[0] = i0.pixValid;
  assign v_o[1] = i1.pixValid;
  assign v_o[2] = i2.pixValid;
  assign v_o[3] = i3.pixValid;
  assign fs_o[0] = i0.frameStart;
  assign fs_o[1] = i1.frameStart;
  assign fs_o[2] = i2.frameStart;
  assign fs_o[3] = i3.frameStart;
  assign ls_o[0] = i0.lineStart;
  assign ls_o[1] = i1.lineStart;
  assign ls_o[2] = i2.lineStart;
  assign ls_o[3] = i3.lineStart;
  assign ab_o[0] = i0.activeBuf;
  assign ab_o[1] = i1.activeBuf;
  assign ab_o[2] = i2.activeBuf;
  assign ab_o[3] = i3.activeBuf;

  int sc [4] = '{1, 1, 0, 2};
  int cur_buf [4] = '{0, 0, 0, 0};
  int last_exp [4] = '{0, 0, 0, 0};
  int checks = 0;
  int failures = 0;

  typedef struct {
    int h;
    int v;
    bit en;
    bit valid;
    int addr;
    bit fs;
    bit ls;
  } vec_t;

  vec_t tbl [7];

  function automatic int exp_addr(int s, int bs, int h, int v);
    int fbw;
    fbw = 640 >> s;
    return (bs != 0 ? fbw * (480 >> s) : 0) +
           ((v - 12) >> s) * fbw + ((h - 112) >> s);
  endfunction

  task automatic chk(string f, int k, int h, int v,
                     logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s d%0d h=%0d v=%0d: got %0d want %0d",
               f, k, h, v, act, exp);
    end
  endtask

  task automatic apply(int h, int v, bit en);
    hor = HOR_W'(h);
    ver = VER_W'(v);
    pix_en = en;
    @(posedge clock);
    #1;
  endtask

  task automatic check_pixel(int h, int v);
    for (int k = 0; k < 4; k++) begin
      int e;
      e = exp_addr(sc[k], cur_buf[k], h, v);
      chk("valid", k, h, v, 32'(v_o[k]), 1);
      chk("addr", k, h, v, a_o[k], e);
      chk("lineStart", k, h, v, 32'(ls_o[k]), 32'(h == 112));
      chk("frameStart", k, h, v, 32'(fs_o[k]),
          32'(h == 112 && v == 12));
      chk("activeBuf", k, h, v, 32'(ab_o[k]), cur_buf[k]);
      last_exp[k] = e;
    end
  endtask

  task automatic check_idle(int h, int v, bit with_addr);
    for (int k = 0; k < 4; k++) begin
      chk("idle_valid", k, h, v, 32'(v_o[k]), 0);
      if (with_addr) chk("idle_hold", k, h, v, a_o[k], last_exp[k]);
    end
  endtask

  task automatic check_reset(int v);
    for (int k = 0; k < 4; k++) begin
      chk("rst_addr", k, 0, v, a_o[k], 0);
      chk("rst_valid", k, 0, v, 32'(v_o[k]), 0);
      chk("rst_fs", k, 0, v, 32'(fs_o[k]), 0);
      chk("rst_ls", k, 0, v, 32'(ls_o[k]), 0);
      chk("rst_abuf", k, 0, v, 32'(ab_o[k]), 0);
      last_exp[k] = 0;
    end
  endtask

  task automatic full_line(int v, int h0);
    for (int h = h0; h <= 751; h++) begin
      apply(h, v, 1'b1);
      check_pixel(h, v);
    end
    apply(752, v, 1'b1);
    check_idle(752, v, 1'b1);
  endtask

  task automatic fast_line(int v);
    apply(112, v, 1'b1);
    check_pixel(112, v);
    apply(751, v, 1'b1);
    for (int k = 0; k < 4; k++) chk("fast_valid", k, 751, v, 32'(v_o[k]), 1);
    apply(752, v, 1'b1);
    check_idle(752, v, 1'b0);
  endtask

  initial begin
    tbl[0] = '{112, 12, 1'b1, 1'b1, 0, 1'b1, 1'b1};
    tbl[1] = '{113, 12, 1'b0, 1'b1, 0, 1'b1, 1'b1};
    tbl[2] = '{113, 12, 1'b1, 1'b1, 0, 1'b0, 1'b0};
    tbl[3] = '{114, 12, 1'b1, 1'b1, 1, 1'b0, 1'b0};
    tbl[4] = '{114, 12, 1'b0, 1'b1, 1, 1'b0, 1'b0};
    tbl[5] = '{115, 12, 1'b1, 1'b1, 1, 1'b0, 1'b0};
    tbl[6] = '{116, 12, 1'b1, 1'b1, 2, 1'b0, 1'b0};

    reset_n = 1'b0;
    pix_en = 1'b0;
    bsel = 1'b1;
    hor = '0;
    ver = VER_W'(200);
    repeat (3) @(posedge clock);
    #1;
    check_reset(200);
    reset_n = 1'b1;

    // out of SYNC only at the top-left pixel
    apply(500, 200, 1'b1);
    check_idle(500, 200, 1'b1);
    apply(112, 13, 1'b1);
    check_idle(112, 13, 1'b1);
    apply(112, 200, 1'b1);
    check_idle(112, 200, 1'b1);

    cur_buf[1] = 1;
    for (int i = 0; i < 7; i++) begin
      apply(tbl[i].h, tbl[i].v, tbl[i].en);
      chk("tbl_valid", 0, tbl[i].h, tbl[i].v, 32'(v_o[0]), 32'(tbl[i].valid));
      chk("tbl_addr", 0, tbl[i].h, tbl[i].v, a_o[0], tbl[i].addr);
      chk("tbl_fs", 0, tbl[i].h, tbl[i].v, 32'(fs_o[0]), 32'(tbl[i].fs));
      chk("tbl_ls", 0, tbl[i].h, tbl[i].v, 32'(ls_o[0]), 32'(tbl[i].ls));
      chk("tbl_abuf", 0, tbl[i].h, tbl[i].v, 32'(ab_o[0]), 0);
      if (i == 0) begin
        chk("dbuf_first", 1, 112, 12, a_o[1], 76800);
        chk("dbuf_abuf", 1, 112, 12, 32'(ab_o[1]), 1);
      end
    end

    full_line(12, 117);
    chk("s1_line_end", 0, 752, 12, a_o[0], 319);
    full_line(13, 112);
    full_line(14, 112);
    for (int v = 15; v <= 490; v++) begin
      if (v == 100) bsel = 1'b0;
      fast_line(v);
    end
    full_line(491, 112);
    chk("s1_last", 0, 752, 491, a_o[0], 76799);
    chk("dbuf_last", 1, 752, 491, a_o[1], 153599);
    chk("s0_last", 2, 752, 491, a_o[2], 307199);
    chk("s2_last", 3, 752, 491, a_o[3], 19199);

    // VBLANK ignores line starts
    apply(112, 492, 1'b1);
    check_idle(112, 492, 1'b1);
    apply(112, 13, 1'b1);
    check_idle(112, 13, 1'b1);

    // second frame picks up the new bufSel
    cur_buf[1] = 0;
    apply(112, 12, 1'b1);
    check_pixel(112, 12);
    chk("dbuf_swap", 1, 112, 12, a_o[1], 0);
    apply(113, 12, 1'b1);
    check_pixel(113, 12);

    // vertical counter jumps out: resync, no line start until frame
    apply(114, 600, 1'b1);
    check_idle(114, 600, 1'b1);
    apply(112, 13, 1'b1);
    check_idle(112, 13, 1'b1);

    apply(112, 12, 1'b1);
    check_pixel(112, 12);
    apply(751, 12, 1'b1);
    apply(112, 200, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk("mid_valid", k, 112, 200, 32'(v_o[k]), 1);
      chk("mid_ls", k, 112, 200, 32'(ls_o[k]), 1);
    end

    // async reset mid-frame
    reset_n = 1'b0;
    #1;
    check_reset(200);
    reset_n = 1'b1;
    apply(113, 200, 1'b1);
    check_idle(113, 200, 1'b1);
    apply(112, 201, 1'b1);
    check_idle(112, 201, 1'b1);
    apply(112, 12, 1'b1);
    check_pixel(112, 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
